fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding, default sizes and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_NUM_REQ = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, BACKOFF} arb_state_e;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker
// Ports:
//   req      in   NUM_REQ  pending requests
//   last_gnt in   IW       index of the most recently granted requester
//   sel      out  IW       winner, searching from last_gnt+1 upward with wrap
//   any_req  out  1        at least one request pending
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_gnt,
    output logic [IW-1:0]      sel,
    output logic               any_req
);
    logic [IW-1:0] idx;
    // Walk the offsets farthest-first so the closest asserted requester after last_gnt is written last.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((32'(last_gnt) + k) % NUM_REQ);
            if (req[idx]) sel = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter funnelling NUM_REQ writers into one FIFO write port with retry on drop
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, req_data     per-requester request and word (slice i = requester i)
//   full, wr_ack,     FIFO status; wr_ack/overflow arrive the cycle after wr_en
//   overflow
//   gnt               one-hot pulse: requester's word accepted
//   wr_en, data_in    FIFO write port
//   ack_count,        saturating grant / retry counters, present only when
//   retry_count       FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    input  logic                          full,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]                   ack_count,
    output logic [15:0]                   retry_count,
`endif
    output logic [FIFO_WIDTH-1:0]         data_in
);
    localparam int IW = idx_w(NUM_REQ);
    arb_state_e state, state_n;
    logic [IW-1:0] sel, last_gnt, pick;
    logic any_req, load, ack;
    logic [FIFO_WIDTH-1:0] words [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end
    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .sel      (pick),
        .any_req  (any_req)
    );
    // sel/data_in load only on IDLE exit, so they stay frozen through retries until the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            last_gnt <= IW'(NUM_REQ - 1);
            data_in  <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                sel     <= pick;
                data_in <= words[pick];
            end
            if (ack) last_gnt <= sel;
        end
    end
    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        gnt     = '0;
        load    = 1'b0;
        ack     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !full) begin
                    load    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                wr_en   = 1'b1;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wr_ack) begin
                    gnt     = NUM_REQ'(1) << sel;
                    ack     = 1'b1;
                    state_n = IDLE;
                end else if (overflow) begin
                    state_n = BACKOFF;
                end else begin
                    // Neither ack nor overflow: the word was silently dropped, retry it the same way.
                    state_n = BACKOFF;
                end
            end
            BACKOFF: state_n = full ? BACKOFF : ISSUE;
            default: state_n = IDLE;
        endcase
    end
`ifdef FIFO_ARB_STATS_EN
    logic retry;
    assign retry = (state == WAIT_ACK) && !wr_ack;
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_count   <= '0;
            retry_count <= '0;
        end else begin
            if (ack && ack_count != 16'hFFFF) ack_count <= ack_count + 16'd1;
            if (retry && retry_count != 16'hFFFF) retry_count <= retry_count + 16'd1;
        end
    end
`endif
endmodule
